cv32e40p_obi_instr_responder: RTL and testbench
===============================================

CV32E40P_OBI_INSTR_RESPONDER -- requirements
Module: cv32e40p_obi_instr_responder

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, maximum number of granted requests without rvalid (legal 1..4).
REQ-002 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of the first word of the backing memory.
REQ-003 SHALL have parameter ADDR_SIZE, default 32'h0001_0000, size of the backing memory in bytes (multiple of 4).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port instr_req_i, input, 1, OBI fetch request from the initiator.
REQ-007 SHALL have port instr_addr_i, input, 32, OBI byte address, valid while instr_req_i=1.
REQ-008 SHALL have port instr_gnt_o, output, 1, OBI grant (address phase accepted).
REQ-009 SHALL have port instr_rvalid_o, output, 1, OBI response valid, one per grant.
REQ-010 SHALL have port instr_rdata_o, output, 32, response word, valid when instr_rvalid_o=1.
REQ-011 SHALL have port instr_err_o, output, 1, response bus error, valid when instr_rvalid_o=1.
REQ-012 SHALL have port gnt_stall_i, input, 1, forces instr_gnt_o=0 (arbitration/verification back-pressure).
REQ-013 SHALL have port rvalid_stall_i, input, 1, forces instr_rvalid_o=0 (slow-memory emulation).
REQ-014 SHALL have port mem_req_o, output, 1, backing memory read strobe.
REQ-015 SHALL have port mem_addr_o, output, 30, word address ((instr_addr_i - ADDR_BASE) >> 2).
REQ-016 SHALL have port mem_rdata_i, input, 32, read data, valid the cycle after mem_req_o=1.

Function
REQ-017 SHALL drive instr_gnt_o combinationally = instr_req_i & ~gnt_stall_i & (outstanding < MAX_OUTSTANDING).
REQ-018 SHALL treat a request as in-range iff instr_addr_i >= ADDR_BASE and (instr_addr_i - ADDR_BASE) < ADDR_SIZE, 32-bit unsigned arithmetic, no wrap beyond 2^32.
REQ-019 SHALL ignore instr_addr_i[1:0]; response is always the aligned word.
REQ-020 SHALL assert mem_req_o = instr_gnt_o & in-range; out-of-range grants never access memory.
REQ-021 SHALL hold a one-entry capture stage set in the cycle after every grant: data = mem_rdata_i, err = 0 (in-range); data = 32'h0, err = 1 (out-of-range).
REQ-022 SHALL buffer captured responses in an in-order FIFO of depth MAX_OUTSTANDING; responses are returned strictly in grant order.
REQ-023 SHALL bypass: when the FIFO is empty, capture stage valid and rvalid_stall_i=0, drive the capture stage directly on instr_rvalid_o/instr_rdata_o/instr_err_o (minimum gnt-to-rvalid latency 1 cycle); otherwise push it to the FIFO.
REQ-024 SHALL drive instr_rvalid_o = (FIFO non-empty or bypass condition) & ~rvalid_stall_i, FIFO head taking priority over the capture stage; pop head when rvalid is driven from the FIFO.
REQ-025 SHALL keep instr_rdata_o and instr_err_o at 0 whenever instr_rvalid_o=0.
REQ-026 SHALL maintain a counter outstanding (0..MAX_OUTSTANDING): +1 on grant, -1 on rvalid, unchanged on both in one cycle.
REQ-027 SHALL never overflow the FIFO (guaranteed by REQ-017); FIFO full with a capture pending is illegal and asserted against.
REQ-028 SHALL accept a new grant in the same cycle as an rvalid that frees the last slot only if outstanding < MAX_OUTSTANDING before the decrement (no combinational path rvalid->gnt).
REQ-029 SHALL tolerate instr_req_i withdrawal or address change without grant (no state change); never issues rvalid without a prior grant.

Reset
REQ-030 SHALL, on rst_n=0 (including mid-transaction), clear outstanding, FIFO pointers and capture stage immediately; instr_gnt_o follows REQ-017 with outstanding=0; instr_rvalid_o, instr_rdata_o, instr_err_o, mem_req_o, mem_addr_o all 0.
REQ-031 SHALL drop all in-flight responses lost by reset; no rvalid is produced for them after reset release.

Verification
REQ-032 Single fetch: req addr 32'h0000_0080, memory word 0x20 = 32'h0011_2233 -> gnt same cycle, mem_addr_o=30'h20, rvalid next cycle with rdata 32'h0011_2233, err 0.
REQ-033 Back-to-back fetches 0x0,0x4,0x8 with rvalid_stall_i=1 for 3 cycles, MAX_OUTSTANDING=2 -> gnt for 0x0,0x4 only, third held; on stall release rvalids in order, third granted in the cycle after first rvalid.
REQ-034 Out-of-range: ADDR_SIZE=32'h1000, req addr 32'h0000_1000 -> gnt, mem_req_o=0, rvalid next cycle with err=1, rdata 0.
REQ-035 gnt_stall_i=1 while req held 5 cycles -> gnt=0, no mem_req, outstanding 0; release -> gnt same cycle.
REQ-036 Reset asserted with 2 outstanding -> outputs 0 asynchronously, after release no rvalid until a new grant.
REQ-037 Unaligned addr 32'h0000_0086 -> mem_addr_o=30'h21, word at 0x84 returned.

Source files
------------

// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-fetch responder: grants fetches, reads a word-addressed backing
// memory and returns responses in grant order, with optional grant/rvalid back-pressure.
module cv32e40p_obi_instr_responder #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE       = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        gnt_stall_i,
  input  logic        rvalid_stall_i,
  output logic        mem_req_o,
  output logic [29:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned        CNT_W   = 3;
  localparam int unsigned        PTR_W   = 2;
  localparam int unsigned        DEPTH   = 4;
  localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [31:0]      fifo_data_q [DEPTH];
  logic             fifo_err_q  [DEPTH];

  logic             cap_valid_q;
  logic             cap_err_q;
  logic [31:0]      cap_data;

  logic [31:0]      offset;
  logic             in_range;
  logic             fifo_empty;
  logic             fifo_full;
  logic             bypass;
  logic             pop;
  logic             push;
  logic             rvalid;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Address decode; the subtraction is only trusted once the lower bound holds,
  // so addresses below the base can never wrap into range.
  assign offset   = instr_addr_i - ADDR_BASE;
  assign in_range = (instr_addr_i >= ADDR_BASE) && (offset < ADDR_SIZE);

  // Grant depends only on registered occupancy, never on this cycle's rvalid.
  assign instr_gnt_o = instr_req_i & ~gnt_stall_i & (outstanding_q < MAX_CNT);
  assign mem_req_o   = instr_gnt_o & in_range & rst_n;
  assign mem_addr_o  = mem_req_o ? offset[31:2] : '0;

  // Memory data arrives the cycle after the strobe, which is exactly when the
  // capture stage is valid; out-of-range captures carry zero data.
  assign cap_data = cap_err_q ? 32'h0 : mem_rdata_i;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == MAX_CNT);
  assign bypass     = fifo_empty & cap_valid_q & ~rvalid_stall_i;
  assign pop        = ~fifo_empty & ~rvalid_stall_i;
  assign push       = cap_valid_q & ~bypass;
  assign rvalid     = pop | bypass;

  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = pop    ? fifo_data_q[rd_ptr_q] :
                          bypass ? cap_data              : 32'h0;
  assign instr_err_o    = pop    ? fifo_err_q[rd_ptr_q]  :
                          bypass ? cap_err_q             : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      fifo_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cap_valid_q   <= 1'b0;
      cap_err_q     <= 1'b0;
    end else begin
      cap_valid_q <= instr_gnt_o;
      cap_err_q   <= instr_gnt_o & ~in_range;

      if (instr_gnt_o && !rvalid) begin
        outstanding_q <= outstanding_q + CNT_W'(1);
      end else if (!instr_gnt_o && rvalid) begin
        outstanding_q <= outstanding_q - CNT_W'(1);
      end

      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: the FIFO storage array is deliberately not reset; entries are only
  // ever read while the count says they hold data, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= cap_data;
      fifo_err_q[wr_ptr_q]  <= cap_err_q;
    end
  end

  // Occupancy bound on grants means a full FIFO can never coexist with a capture.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(cap_valid_q && fifo_full && !pop));

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Self-checking bench for cv32e40p_obi_instr_responder: directed scenarios plus a
// randomized phase, with a grant-order scoreboard checking every response.
module tb_cv32e40p_obi_instr_responder;

  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] SIZE    = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        gnt_stall_i;
  logic        rvalid_stall_i;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_rdata_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  cv32e40p_obi_instr_responder #(
    .MAX_OUTSTANDING(MAX_OUT),
    .ADDR_BASE      (32'h0000_0000),
    .ADDR_SIZE      (SIZE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .gnt_stall_i   (gnt_stall_i),
    .rvalid_stall_i(rvalid_stall_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (wa == 30'h20) return 32'h0011_2233;
    return {2'b10, wa} ^ 32'h0000_A5A5;
  endfunction

  // Backing memory: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) begin
    mem_rdata_i <= mem_req_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;
  end

  function automatic resp_t expect_for(input logic [31:0] a);
    resp_t r;
    r.addr = a;
    if (a < SIZE) begin
      r.data = mem_word(a[31:2]);
      r.err  = 1'b0;
    end else begin
      r.data = 32'h0;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard monitor: queue size equals the responder's outstanding count
  // at the start of each cycle, which also predicts the grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      n_cmp++;
      if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 || instr_err_o !== 1'b0 ||
          mem_req_o !== 1'b0 || mem_addr_o !== 30'h0) begin
        n_bad++;
        $display("FAIL mon_reset_outputs: rvalid=%b rdata=%h err=%b mem_req=%b mem_addr=%h, want all 0",
                 instr_rvalid_o, instr_rdata_o, instr_err_o, mem_req_o, mem_addr_o);
      end
    end else begin
      logic exp_gnt;
      exp_gnt = instr_req_i & ~gnt_stall_i & (sb.size() < MAX_OUT);
      n_cmp++;
      if (instr_gnt_o !== exp_gnt) begin
        n_bad++;
        $display("FAIL mon_gnt: got %b want %b (outstanding %0d)", instr_gnt_o, exp_gnt, sb.size());
      end
      if (instr_rvalid_o === 1'b1) begin
        n_cmp++;
        if (rvalid_stall_i) begin
          n_bad++;
          $display("FAIL mon_rvalid_stall: rvalid 1 while stalled, want 0");
        end else if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL mon_spurious_rvalid: rvalid 1 with no grant outstanding, want 0");
        end else begin
          resp_t e;
          e = sb.pop_front();
          if (instr_rdata_o !== e.data || instr_err_o !== e.err) begin
            n_bad++;
            $display("FAIL mon_resp addr=%h: got rdata=%h err=%b want rdata=%h err=%b",
                     e.addr, instr_rdata_o, instr_err_o, e.data, e.err);
          end
        end
      end else begin
        n_cmp++;
        if (instr_rdata_o !== 32'h0 || instr_err_o !== 1'b0) begin
          n_bad++;
          $display("FAIL mon_idle_data: rdata=%h err=%b with rvalid 0, want 0/0",
                   instr_rdata_o, instr_err_o);
        end
      end
      if (instr_gnt_o === 1'b1) sb.push_back(expect_for(instr_addr_i));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: gnt=%b rvalid=%b want 0/0", instr_gnt_o, instr_rvalid_o);
    end
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0080;
    #1;
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b0 || mem_addr_o !== 30'h0) begin
      n_bad++;
      $display("FAIL reset_req: gnt=%b mem_req=%b mem_addr=%h want 1/0/0",
               instr_gnt_o, mem_req_o, mem_addr_o);
    end
    instr_req_i = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    cyc();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0080;
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 30'h20) begin
      n_bad++;
      $display("FAIL single_addr_phase: gnt=%b mem_req=%b mem_addr=%h want 1/1/20",
               instr_gnt_o, mem_req_o, mem_addr_o);
    end
    cyc();
    instr_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h0011_2233 || instr_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_resp: rvalid=%b rdata=%h err=%b want 1/00112233/0",
               instr_rvalid_o, instr_rdata_o, instr_err_o);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    rvalid_stall_i = 1'b1;
    instr_req_i    = 1'b1;
    instr_addr_i   = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_gnt0: got %b want 1", instr_gnt_o);
    end
    cyc();
    instr_addr_i = 32'h4;
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || instr_rvalid_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gnt1: gnt=%b rvalid=%b want 1/0", instr_gnt_o, instr_rvalid_o);
    end
    cyc();
    instr_addr_i = 32'h8;
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_held: gnt=%b want 0", instr_gnt_o);
    end
    cyc();
    rvalid_stall_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(30'h0) || instr_gnt_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first_resp: rvalid=%b rdata=%h gnt=%b want 1/%h/0",
               instr_rvalid_o, instr_rdata_o, instr_gnt_o, mem_word(30'h0));
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(30'h1)) begin
      n_bad++;
      $display("FAIL b2b_second: gnt=%b rvalid=%b rdata=%h want 1/1/%h",
               instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_word(30'h1));
    end
    cyc();
    instr_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(30'h2)) begin
      n_bad++;
      $display("FAIL b2b_third: rvalid=%b rdata=%h want 1/%h",
               instr_rvalid_o, instr_rdata_o, mem_word(30'h2));
    end
    cyc();
  endtask

  task automatic test_out_of_range();
    logic [31:0] oor [2];
    oor[0] = 32'h0000_1000;
    oor[1] = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      instr_req_i  = 1'b1;
      instr_addr_i = oor[i];
      @(negedge clk);
      n_cmp++;
      if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin
        n_bad++;
        $display("FAIL oor_addr_phase %h: gnt=%b mem_req=%b want 1/0", oor[i], instr_gnt_o, mem_req_o);
      end
      cyc();
      instr_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b1 || instr_rdata_o !== 32'h0) begin
        n_bad++;
        $display("FAIL oor_resp %h: rvalid=%b err=%b rdata=%h want 1/1/0",
                 oor[i], instr_rvalid_o, instr_err_o, instr_rdata_o);
      end
      cyc();
    end
  endtask

  task automatic test_gnt_stall();
    gnt_stall_i  = 1'b1;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (instr_gnt_o !== 1'b0 || mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL gstall_cycle%0d: gnt=%b mem_req=%b rvalid=%b want 0/0/0",
                 i, instr_gnt_o, mem_req_o, instr_rvalid_o);
      end
      cyc();
    end
    gnt_stall_i = 1'b0;
    #1;
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL gstall_release: gnt=%b mem_req=%b want 1/1", instr_gnt_o, mem_req_o);
    end
    cyc();
    instr_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    rvalid_stall_i = 1'b1;
    instr_req_i    = 1'b1;
    instr_addr_i   = 32'h0000_0040;
    cyc();
    instr_addr_i = 32'h0000_0044;
    cyc();
    instr_req_i    = 1'b0;
    rvalid_stall_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(30'h10)) begin
      n_bad++;
      $display("FAIL rmid_pre: rvalid=%b rdata=%h want 1/%h", instr_rvalid_o, instr_rdata_o, mem_word(30'h10));
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_async: rvalid=%b rdata=%h mem_req=%b want 0/0/0",
               instr_rvalid_o, instr_rdata_o, mem_req_o);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (instr_rvalid_o !== 1'b0) begin
        n_bad++; $display("FAIL rmid_after%0d: rvalid=%b want 0", i, instr_rvalid_o);
      end
      cyc();
    end
  endtask

  task automatic test_unaligned();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0086;
    @(negedge clk);
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || mem_addr_o !== 30'h21) begin
      n_bad++; $display("FAIL unaligned_addr: gnt=%b mem_addr=%h want 1/21", instr_gnt_o, mem_addr_o);
    end
    cyc();
    instr_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(30'h21)) begin
      n_bad++;
      $display("FAIL unaligned_resp: rvalid=%b rdata=%h want 1/%h",
               instr_rvalid_o, instr_rdata_o, mem_word(30'h21));
    end
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      instr_req_i    = ($urandom_range(0, 3) != 0);
      instr_addr_i   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                                     : $urandom_range(0, 32'h17FF);
      gnt_stall_i    = ($urandom_range(0, 4) == 0);
      rvalid_stall_i = ($urandom_range(0, 3) == 0);
      cyc();
    end
    instr_req_i    = 1'b0;
    gnt_stall_i    = 1'b0;
    rvalid_stall_i = 1'b0;
    repeat (8) cyc();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL random_drain: %0d responses never returned, want 0", sb.size());
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_req_i    = 1'b0;
    instr_addr_i   = 32'h0;
    gnt_stall_i    = 1'b0;
    rvalid_stall_i = 1'b0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_out_of_range();
    test_gnt_stall();
    test_reset_mid();
    test_unaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
